// File: rtl/ad_conv_sched.sv
// rtl/ad_conv_sched.sv - round-robin scheduler sharing one AD conversion engine among four channels
module ad_conv_sched #(
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:1] ad_start,
  input  logic       conv_done,
  input  logic       flag_clr,
  output logic       conv_start,
  output logic [1:0] conv_ch,
  output logic       busy,
  output logic [4:1] pending,
  output logic [4:1] overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  // WAIT aborts once the incremented count would reach CONV_TIMEOUT-1
  localparam logic [15:0] TO_LAST = 16'(CONV_TIMEOUT - 2);

  state_t      state_q, state_d;
  logic [3:0]  start_v, start_d, edge_v, pend_q, ovr_q, grant_v;
  logic [1:0]  last_ch, sel, idx;
  logic        found, grant, done_ev, tmo_ev;
  logic [15:0] cnt;

  assign start_v = ad_start;
  assign edge_v  = start_v & ~start_d & {4{enable}};
  assign found   = |pend_q;
  assign grant_v = grant ? (4'b0001 << sel) : 4'b0000;

  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_ch + 2'(k);
      if (pend_q[idx]) sel = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done_ev = 1'b0;
    tmo_ev  = 1'b0;
    case (state_q)
      IDLE: if (enable && found) begin
        grant   = 1'b1;
        state_d = START;
      end
      START: state_d = WAIT;
      WAIT: if (conv_done) begin
        done_ev = 1'b1;
        state_d = IDLE;
      end else if (cnt == TO_LAST) begin
        tmo_ev  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d     <= 4'b0000;
      pend_q      <= 4'b0000;
      ovr_q       <= 4'b0000;
      timeout_err <= 1'b0;
      conv_ch     <= 2'd0;
      last_ch     <= 2'd3;
      cnt         <= 16'd0;
    end else begin
      start_d <= start_v;
      if (!enable) pend_q <= 4'b0000;
      else         pend_q <= (pend_q & ~grant_v) | edge_v;
      // a set in the same cycle as flag_clr wins
      ovr_q <= (ovr_q & ~{4{flag_clr}}) | (edge_v & pend_q & ~grant_v);
      if (tmo_ev)        timeout_err <= 1'b1;
      else if (flag_clr) timeout_err <= 1'b0;
      if (grant) conv_ch <= sel;
      if (done_ev || tmo_ev) last_ch <= conv_ch;
      if (state_q == START) cnt <= 16'd0;
      else if (state_q == WAIT && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  assign conv_start = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign pending    = pend_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ad_conv_sched.sv
// tb/tb_ad_conv_sched.sv - vector table and directed sequences for ad_conv_sched
module tb_ad_conv_sched;

  logic       clk, rst, enable, conv_done, flag_clr;
  logic [3:0] ad;
  logic       conv_start, busy, timeout_err;
  logic [1:0] conv_ch;
  logic [3:0] pending, overrun;

  int total = 0;
  int bad   = 0;
  int got[$];

  ad_conv_sched #(.CONV_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ad_start(ad),
    .conv_done(conv_done), .flag_clr(flag_clr),
    .conv_start(conv_start), .conv_ch(conv_ch), .busy(busy),
    .pending(pending), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] ad;
    logic       done;
    logic       clr;
    logic       cs;
    logic [1:0] ch;
    logic       bsy;
    logic [3:0] pend;
    logic [3:0] ovr;
    logic       to;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t v(input logic en, input logic [3:0] a, input logic d, input logic c,
                             input logic cs, input logic [1:0] ch, input logic b,
                             input logic [3:0] p, input logic [3:0] o, input logic t);
    vec_t r;
    r.en = en; r.ad = a; r.done = d; r.clr = c;
    r.cs = cs; r.ch = ch; r.bsy = b; r.pend = p; r.ovr = o; r.to = t;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; ad = 4'b0; conv_done = 1'b0; flag_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    enable = 1'b1;
  endtask

  // engine model: conv_done follows each conv_start after dly cycles
  task automatic serve(input int n, input int dly);
    int seen = 0;
    int cd = -1;
    int budget = 0;
    got.delete();
    while ((seen < n || busy) && budget < 300) begin
      conv_done = (cd == 0);
      tick();
      budget++;
      if (cd > 0) cd--;
      else if (cd == 0) cd = -1;
      if (conv_start) begin
        got.push_back(int'(conv_ch));
        seen++;
        cd = dly;
      end
    end
    conv_done = 1'b0;
    chk("serve_budget", 16'(budget < 300), 16'd1);
  endtask

  initial begin
    int n;
    tbl[0]  = v(1, 4'b0010, 0, 0, 0, 2'd0, 0, 4'b0010, 4'b0000, 0);
    tbl[1]  = v(1, 4'b0010, 0, 0, 1, 2'd1, 1, 4'b0000, 4'b0000, 0);
    tbl[2]  = v(1, 4'b0000, 0, 0, 0, 2'd1, 1, 4'b0000, 4'b0000, 0);
    tbl[3]  = v(1, 4'b0001, 0, 0, 0, 2'd1, 1, 4'b0001, 4'b0000, 0);
    tbl[4]  = v(1, 4'b0000, 0, 0, 0, 2'd1, 1, 4'b0001, 4'b0000, 0);
    tbl[5]  = v(1, 4'b0001, 0, 0, 0, 2'd1, 1, 4'b0001, 4'b0001, 0);
    tbl[6]  = v(1, 4'b0000, 1, 0, 0, 2'd1, 0, 4'b0001, 4'b0001, 0);
    tbl[7]  = v(1, 4'b0000, 0, 1, 1, 2'd0, 1, 4'b0000, 4'b0000, 0);
    tbl[8]  = v(1, 4'b0001, 0, 0, 0, 2'd0, 1, 4'b0001, 4'b0000, 0);
    tbl[9]  = v(1, 4'b0000, 1, 0, 0, 2'd0, 0, 4'b0001, 4'b0000, 0);
    tbl[10] = v(1, 4'b0001, 0, 0, 1, 2'd0, 1, 4'b0001, 4'b0000, 0);
    tbl[11] = v(1, 4'b0000, 1, 0, 0, 2'd0, 1, 4'b0001, 4'b0000, 0);
    tbl[12] = v(1, 4'b0000, 0, 0, 0, 2'd0, 1, 4'b0001, 4'b0000, 0);
    tbl[13] = v(1, 4'b0000, 1, 0, 0, 2'd0, 0, 4'b0001, 4'b0000, 0);
    tbl[14] = v(0, 4'b0000, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 0);
    tbl[15] = v(1, 4'b0000, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 0);

    do_reset();
    chk("rst_conv_start", 16'(conv_start), 16'd0);
    chk("rst_conv_ch", 16'(conv_ch), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_pending", 16'(pending), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_timeout", 16'(timeout_err), 16'd0);

    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en; ad = tbl[i].ad; conv_done = tbl[i].done; flag_clr = tbl[i].clr;
      tick();
      chk($sformatf("row%0d_cs", i), 16'(conv_start), 16'(tbl[i].cs));
      chk($sformatf("row%0d_ch", i), 16'(conv_ch), 16'(tbl[i].ch));
      chk($sformatf("row%0d_busy", i), 16'(busy), 16'(tbl[i].bsy));
      chk($sformatf("row%0d_pend", i), 16'(pending), 16'(tbl[i].pend));
      chk($sformatf("row%0d_ovr", i), 16'(overrun), 16'(tbl[i].ovr));
      chk($sformatf("row%0d_to", i), 16'(timeout_err), 16'(tbl[i].to));
    end
    conv_done = 1'b0; flag_clr = 1'b0;

    // single request: busy spans START plus ten WAIT cycles
    do_reset();
    ad = 4'b0010;
    tick();
    tick();
    ad = 4'b0000;
    chk("single_cs", 16'(conv_start), 16'd1);
    chk("single_ch", 16'(conv_ch), 16'd1);
    n = 1;
    for (int i = 1; i <= 11; i++) begin
      conv_done = (i == 11);
      tick();
      if (busy) n++;
    end
    conv_done = 1'b0;
    chk("single_busy_cycles", 16'(n), 16'd11);
    chk("single_idle", 16'(busy), 16'd0);
    chk("single_pend", 16'(pending), 16'd0);
    chk("single_flags", 16'({overrun, timeout_err}), 16'd0);

    // round robin from reset, then 0 and 3 with last_ch=3
    do_reset();
    ad = 4'b1111;
    tick();
    ad = 4'b0000;
    serve(4, 5);
    chk("rr4_count", 16'(got.size()), 16'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("rr4_grant%0d", i), 16'(got[i]), 16'(i));
    ad = 4'b1001;
    tick();
    ad = 4'b0000;
    serve(2, 5);
    chk("rr2_count", 16'(got.size()), 16'd2);
    if (got.size() == 2) begin
      chk("rr2_first", 16'(got[0]), 16'd0);
      chk("rr2_second", 16'(got[1]), 16'd3);
    end
    chk("rr_flags", 16'({overrun, timeout_err}), 16'd0);

    // timeout: no conv_done, back in IDLE 16 cycles after START
    do_reset();
    ad = 4'b0101;
    tick();
    ad = 4'b0000;
    tick();
    chk("to_start_ch", 16'(conv_ch), 16'd0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (!busy) break;
    end
    chk("to_cycles", 16'(n), 16'd16);
    chk("to_err", 16'(timeout_err), 16'd1);
    tick();
    chk("to_next_cs", 16'(conv_start), 16'd1);
    chk("to_next_ch", 16'(conv_ch), 16'd2);
    for (int i = 1; i <= 16; i++) begin
      flag_clr = (i == 16);
      tick();
    end
    flag_clr = 1'b0;
    chk("to_clr_same_busy", 16'(busy), 16'd0);
    chk("to_clr_same_err", 16'(timeout_err), 16'd1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("to_clr_err", 16'(timeout_err), 16'd0);

    // enable drop during WAIT
    do_reset();
    ad = 4'b0001;
    tick();
    ad = 4'b0000;
    tick();
    tick();
    ad = 4'b0110;
    tick();
    ad = 4'b0000;
    chk("en_pend_before", 16'(pending), 16'b0110);
    enable = 1'b0;
    tick();
    chk("en_pend_cleared", 16'(pending), 16'd0);
    chk("en_still_busy", 16'(busy), 16'd1);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("en_done_idle", 16'(busy), 16'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) enable = 1'b1;
      tick();
      if (conv_start || busy) n++;
    end
    chk("en_no_grant", 16'(n), 16'd0);
    ad = 4'b1000;
    tick();
    ad = 4'b0000;
    tick();
    chk("en_new_cs", 16'(conv_start), 16'd1);
    chk("en_new_ch", 16'(conv_ch), 16'd3);
    serve(0, 2);

    // async reset mid-WAIT
    do_reset();
    ad = 4'b0010;
    tick();
    ad = 4'b0000;
    tick();
    tick();
    ad = 4'b0001;
    tick();
    ad = 4'b0000;
    chk("rw_busy_pre", 16'(busy), 16'd1);
    rst = 1'b1;
    #2;
    chk("rw_busy", 16'(busy), 16'd0);
    chk("rw_ch", 16'(conv_ch), 16'd0);
    chk("rw_pend", 16'(pending), 16'd0);
    chk("rw_cs", 16'(conv_start), 16'd0);
    tick();
    rst = 1'b0;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("rw_late_done_busy", 16'(busy), 16'd0);
    chk("rw_late_done_ch", 16'(conv_ch), 16'd0);
    ad = 4'b0011;
    tick();
    ad = 4'b0000;
    tick();
    chk("rw_first_cs", 16'(conv_start), 16'd1);
    chk("rw_first_ch", 16'(conv_ch), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
